// File: rtl/frame_arb_pkg.sv
// Shared definitions for the frame-granular stream arbiter: FSM encoding and
// default frame geometry of the blur accelerator input.
package frame_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ARB  = 2'd1,
        ST_XFER = 2'd2
    } arb_state_t;

    localparam int DEF_FRAME_W = 258;
    localparam int DEF_FRAME_H = 258;
    localparam int FRAME_PIX   = DEF_FRAME_W * DEF_FRAME_H;

endpackage

// File: rtl/frame_pos_counter.sv
// Raster position tracker: column/row counters advanced per accepted pixel,
// flagging the final pixel of a frame.
module frame_pos_counter #(
    parameter int FRAME_W = 258,
    parameter int FRAME_H = 258,
    parameter int XW      = 9,
    parameter int YW      = 9
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic at_last
);

    localparam logic [XW-1:0] X_MAX = XW'(FRAME_W - 1);
    localparam logic [YW-1:0] Y_MAX = YW'(FRAME_H - 1);

    logic [XW-1:0] x_r;
    logic [YW-1:0] y_r;
    logic          x_end_s;
    logic          y_end_s;

    assign x_end_s = (x_r == X_MAX);
    assign y_end_s = (y_r == Y_MAX);
    assign at_last = x_end_s && y_end_s;

    // Column/row counters: x wraps at row end, y wraps at frame end.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            x_r <= {XW{1'b0}};
            y_r <= {YW{1'b0}};
        end else if (en) begin
            if (x_end_s) begin
                x_r <= {XW{1'b0}};
                y_r <= y_end_s ? {YW{1'b0}} : (y_r + YW'(1));
            end else begin
                x_r <= x_r + XW'(1);
            end
        end
    end

endmodule

// File: rtl/frame_stream_arbiter.sv
// Round-robin 2:1 whole-frame arbiter with zero-latency pass-through, generated
// end-of-frame marker and source last-mismatch detection.
module frame_stream_arbiter
    import frame_arb_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int FRAME_W = DEF_FRAME_W,
    parameter int FRAME_H = DEF_FRAME_H,
    parameter int XW      = 9,
    parameter int YW      = 9
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start_in,
    input  logic              stop_in,
    input  logic [DATA_W-1:0] s0_data,
    input  logic              s0_valid,
    input  logic              s0_last,
    output logic              s0_ready,
    input  logic [DATA_W-1:0] s1_data,
    input  logic              s1_valid,
    input  logic              s1_last,
    output logic              s1_ready,
    output logic [DATA_W-1:0] m_data,
    output logic              m_valid,
    output logic              m_last,
    input  logic              m_ready,
    output logic              grant_id,
    output logic              busy,
    output logic              frame_done,
    output logic              err_last,
    output logic [15:0]       frame_count
);

    arb_state_t  state_r, state_nx;
    logic        grant_id_r, grant_nx;
    logic        last_grant_r;
    logic        stop_pend_r, stop_pend_nx;
    logic        busy_r;
    logic        frame_done_r;
    logic        err_last_r;
    logic [15:0] frame_count_r;

    logic        winner_s;
    logic        g_last_s;
    logic        at_last_s;
    logic        fire_s;
    logic        frame_end_s;

    frame_pos_counter #(
        .FRAME_W (FRAME_W),
        .FRAME_H (FRAME_H),
        .XW      (XW),
        .YW      (YW)
    ) u_pos (
        .clk     (clk),
        .reset   (reset),
        .clr     (state_r == ST_IDLE),
        .en      (fire_s),
        .at_last (at_last_s)
    );

    // Pass-through mux: only the granted source sees m_ready, nothing flows outside XFER.
    always_comb begin
        m_data   = {DATA_W{1'b0}};
        m_valid  = 1'b0;
        s0_ready = 1'b0;
        s1_ready = 1'b0;
        g_last_s = 1'b0;
        if (state_r == ST_XFER) begin
            if (grant_id_r) begin
                m_data   = s1_data;
                m_valid  = s1_valid;
                s1_ready = m_ready;
                g_last_s = s1_last;
            end else begin
                m_data   = s0_data;
                m_valid  = s0_valid;
                s0_ready = m_ready;
                g_last_s = s0_last;
            end
        end else begin
            m_data  = {DATA_W{1'b0}};
            m_valid = 1'b0;
        end
        m_last = at_last_s && m_valid;
    end

    assign fire_s      = m_valid && m_ready;
    assign frame_end_s = fire_s && at_last_s;

    // Round-robin pick: on a tie the source that did not own the previous frame wins.
    always_comb begin
        winner_s = 1'b0;
        if (s0_valid && s1_valid) begin
            winner_s = ~last_grant_r;
        end else begin
            winner_s = s1_valid;
        end
    end

    // Next-state logic for the frame FSM and the grant latch.
    always_comb begin
        state_nx = state_r;
        grant_nx = grant_id_r;
        case (state_r)
            ST_IDLE: begin
                if (start_in) begin
                    state_nx = ST_ARB;
                end else begin
                    state_nx = ST_IDLE;
                end
            end
            ST_ARB: begin
                if (stop_pend_r) begin
                    state_nx = ST_IDLE;
                end else if (s0_valid || s1_valid) begin
                    state_nx = ST_XFER;
                    grant_nx = winner_s;
                end else begin
                    state_nx = ST_ARB;
                end
            end
            ST_XFER: begin
                if (frame_end_s) begin
                    state_nx = ST_ARB;
                end else begin
                    state_nx = ST_XFER;
                end
            end
            default: begin
                state_nx = ST_IDLE;
            end
        endcase
    end

    // Pending stop: a stop request beats a simultaneous start and is consumed by ARB.
    always_comb begin
        stop_pend_nx = stop_pend_r;
        if (stop_in) begin
            stop_pend_nx = 1'b1;
        end else if (start_in) begin
            stop_pend_nx = 1'b0;
        end else if ((state_r == ST_ARB) && stop_pend_r) begin
            stop_pend_nx = 1'b0;
        end else begin
            stop_pend_nx = stop_pend_r;
        end
    end

    // Control, statistics and error registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r       <= ST_IDLE;
            grant_id_r    <= 1'b0;
            last_grant_r  <= 1'b1;
            stop_pend_r   <= 1'b0;
            busy_r        <= 1'b0;
            frame_done_r  <= 1'b0;
            err_last_r    <= 1'b0;
            frame_count_r <= 16'd0;
        end else begin
            state_r      <= state_nx;
            grant_id_r   <= grant_nx;
            stop_pend_r  <= stop_pend_nx;
            busy_r       <= (state_nx != ST_IDLE);
            frame_done_r <= frame_end_s;
            if (frame_end_s) begin
                last_grant_r  <= grant_id_r;
                frame_count_r <= frame_count_r + 16'd1;
            end
            if (fire_s && (g_last_s != m_last)) begin
                err_last_r <= 1'b1;
            end
        end
    end

    assign grant_id    = grant_id_r;
    assign busy        = busy_r;
    assign frame_done  = frame_done_r;
    assign err_last    = err_last_r;
    assign frame_count = frame_count_r;

endmodule
